// File: rtl/can_frame_receiver.sv
// rtl/can_frame_receiver.sv - CAN 2.0A receive node: sync, destuff, parse, CRC/form/stuff check, ACK
module can_frame_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 5,
    parameter int STUFF_EN     = 1
) (
    input  logic        can_clk,
    input  logic        reset,
    input  logic        can_lo_in,
    output logic        can_hi_out,
    output logic        can_lo_out,
    output logic [10:0] rx_id,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        crc_err,
    output logic        form_err,
    output logic        stuff_err,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] SP   = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        ST_INTEGRATE, ST_IDLE, ST_ARB, ST_CTRL, ST_DATA, ST_CRC,
        ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF, ST_ERROR
    } state_t;

    state_t        state;
    logic          sync1, sync2, prev;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    integ_cnt;
    logic [6:0]    fcnt;
    logic [6:0]    nbits;
    logic [10:0]   id_sr;
    logic          rtr_sr;
    logic [3:0]    dlc_sr;
    logic [63:0]   data_sr;
    logic [14:0]   crc_rx;
    logic [14:0]   crc;
    logic          run_val;
    logic [2:0]    run_len;
    logic          stuffing;

    logic          bus_bit;
    logic          hard_sync;
    logic          sample;
    logic          stuff_slot;
    logic [14:0]   crc_step;
    logic [2:0]    run_next;
    logic [3:0]    dlc_full;
    logic [6:0]    nbits_calc;

    assign bus_bit    = sync2;
    assign hard_sync  = (state == ST_IDLE) && prev && !sync2;
    assign sample     = (bit_cnt == SP) && !hard_sync;
    assign stuff_slot = (STUFF_EN != 0) && stuffing && (run_len == 3'd5);
    assign crc_step   = {crc[13:0], 1'b0} ^ ((bus_bit ^ crc[14]) ? 15'h4599 : 15'h0000);
    assign run_next   = (bus_bit == run_val) ? run_len + 3'd1 : 3'd1;
    assign dlc_full   = {dlc_sr[2:0], bus_bit};
    assign nbits_calc = rtr_sr ? 7'd0 : (dlc_full > 4'd8) ? 7'd64 : {dlc_full, 3'b000};
    assign busy       = (state != ST_IDLE) && (state != ST_INTEGRATE);

    always_ff @(posedge can_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INTEGRATE;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev       <= 1'b1;
            bit_cnt    <= '0;
            integ_cnt  <= '0;
            fcnt       <= '0;
            nbits      <= '0;
            id_sr      <= '0;
            rtr_sr     <= 1'b0;
            dlc_sr     <= '0;
            data_sr    <= '0;
            crc_rx     <= '0;
            crc        <= '0;
            run_val    <= 1'b1;
            run_len    <= '0;
            stuffing   <= 1'b0;
            can_hi_out <= 1'b0;
            can_lo_out <= 1'b1;
            rx_id      <= '0;
            rx_rtr     <= 1'b0;
            rx_dlc     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            crc_err    <= 1'b0;
            form_err   <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            sync1     <= can_lo_in;
            sync2     <= sync1;
            prev      <= sync2;
            rx_valid  <= 1'b0;
            crc_err   <= 1'b0;
            form_err  <= 1'b0;
            stuff_err <= 1'b0;
            bit_cnt   <= (hard_sync || bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);

            // ACK drive toggles only on the bit boundary so it spans exactly one bit time
            if (bit_cnt == LAST) begin
                can_hi_out <= (state == ST_ACK);
                can_lo_out <= (state != ST_ACK);
            end

            if (state == ST_ERROR) begin
                state     <= ST_INTEGRATE;
                integ_cnt <= '0;
                stuffing  <= 1'b0;
            end else if (sample) begin
                if (stuff_slot) begin
                    if (bus_bit == run_val) begin
                        stuff_err <= 1'b1;
                        state     <= ST_ERROR;
                    end
                    run_val <= bus_bit;
                    run_len <= 3'd1;
                end else begin
                    if (state inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC}) begin
                        run_val <= bus_bit;
                        run_len <= run_next;
                    end
                    case (state)
                        ST_INTEGRATE: begin
                            if (!bus_bit) begin
                                integ_cnt <= '0;
                            end else if (integ_cnt == 4'd10) begin
                                integ_cnt <= '0;
                                state     <= ST_IDLE;
                            end else begin
                                integ_cnt <= integ_cnt + 4'd1;
                            end
                        end
                        ST_IDLE: begin
                            if (!bus_bit) begin
                                state    <= ST_ARB;
                                fcnt     <= '0;
                                crc      <= '0;
                                data_sr  <= '0;
                                run_val  <= 1'b0;
                                run_len  <= 3'd1;
                                stuffing <= 1'b1;
                            end
                        end
                        ST_ARB: begin
                            crc <= crc_step;
                            if (fcnt == 7'd11) begin
                                rtr_sr <= bus_bit;
                                fcnt   <= '0;
                                state  <= ST_CTRL;
                            end else begin
                                id_sr <= {id_sr[9:0], bus_bit};
                                fcnt  <= fcnt + 7'd1;
                            end
                        end
                        ST_CTRL: begin
                            crc  <= crc_step;
                            fcnt <= fcnt + 7'd1;
                            if (fcnt >= 7'd2) dlc_sr <= dlc_full;
                            if (fcnt == 7'd0 && bus_bit) begin
                                form_err <= 1'b1;
                                state    <= ST_ERROR;
                            end else if (fcnt == 7'd5) begin
                                fcnt  <= '0;
                                nbits <= nbits_calc;
                                state <= (nbits_calc == 7'd0) ? ST_CRC : ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            crc <= crc_step;
                            // ~fcnt[5:0] == 63 - fcnt: first received bit lands in bit 63
                            data_sr[~fcnt[5:0]] <= bus_bit;
                            if (fcnt == nbits - 7'd1) begin
                                fcnt  <= '0;
                                state <= ST_CRC;
                            end else begin
                                fcnt <= fcnt + 7'd1;
                            end
                        end
                        ST_CRC: begin
                            crc_rx <= {crc_rx[13:0], bus_bit};
                            if (fcnt == 7'd14) begin
                                fcnt  <= '0;
                                state <= ST_CRC_DEL;
                            end else begin
                                fcnt <= fcnt + 7'd1;
                            end
                        end
                        ST_CRC_DEL: begin
                            stuffing <= 1'b0;
                            if (!bus_bit) begin
                                form_err <= 1'b1;
                                state    <= ST_ERROR;
                            end else if (crc_rx != crc) begin
                                crc_err <= 1'b1;
                                state   <= ST_ERROR;
                            end else begin
                                state <= ST_ACK;
                            end
                        end
                        ST_ACK: state <= ST_ACK_DEL;
                        ST_ACK_DEL: begin
                            fcnt <= '0;
                            if (!bus_bit) begin
                                form_err <= 1'b1;
                                state    <= ST_ERROR;
                            end else begin
                                state <= ST_EOF;
                            end
                        end
                        ST_EOF: begin
                            if (!bus_bit) begin
                                form_err <= 1'b1;
                                state    <= ST_ERROR;
                            end else if (fcnt == 7'd6) begin
                                rx_valid  <= 1'b1;
                                rx_id     <= id_sr;
                                rx_rtr    <= rtr_sr;
                                rx_dlc    <= dlc_sr;
                                rx_data   <= data_sr;
                                integ_cnt <= '0;
                                state     <= ST_INTEGRATE;
                            end else begin
                                fcnt <= fcnt + 7'd1;
                            end
                        end
                        default: state <= ST_INTEGRATE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_can_frame_receiver.sv
// tb/tb_can_frame_receiver.sv - randomized self-checking bench for can_frame_receiver
module tb_can_frame_receiver;
    localparam int CPB = 8;
    typedef logic bitq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx = 1'b1, tx2 = 1'b1;
    logic lo_in, lo_in2;
    logic can_hi_out, can_lo_out, rx_rtr, rx_valid, crc_err, form_err, stuff_err, busy;
    logic [10:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic hi2, lo_out2, rtr2, valid2, crc2, form2, stuff2, busy2;
    logic [10:0] id2;
    logic [3:0]  dlc2;
    logic [63:0] data2;

    assign lo_in  = tx & can_lo_out;
    assign lo_in2 = tx2 & lo_out2;

    can_frame_receiver #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(5), .STUFF_EN(1)) dut (
        .can_clk(clk), .reset(rst_n), .can_lo_in(lo_in), .can_hi_out(can_hi_out),
        .can_lo_out(can_lo_out), .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
        .rx_data(rx_data), .rx_valid(rx_valid), .crc_err(crc_err), .form_err(form_err),
        .stuff_err(stuff_err), .busy(busy));

    can_frame_receiver #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(5), .STUFF_EN(0)) dut_ns (
        .can_clk(clk), .reset(rst_n), .can_lo_in(lo_in2), .can_hi_out(hi2),
        .can_lo_out(lo_out2), .rx_id(id2), .rx_rtr(rtr2), .rx_dlc(dlc2),
        .rx_data(data2), .rx_valid(valid2), .crc_err(crc2), .form_err(form2),
        .stuff_err(stuff2), .busy(busy2));

    always #5 clk = ~clk;

    int tests_run = 0, tests_failed = 0;
    int n_valid = 0, n_crc = 0, n_form = 0, n_stuff = 0, n_ack = 0, n_valid2 = 0;
    int b_valid, b_crc, b_form, b_stuff, b_ack, b_valid2;
    logic [10:0] exp_id;
    logic        exp_rtr;
    logic [3:0]  exp_dlc;
    logic [63:0] exp_data;

    always @(negedge clk) begin
        if (rx_valid)   n_valid  <= n_valid + 1;
        if (crc_err)    n_crc    <= n_crc + 1;
        if (form_err)   n_form   <= n_form + 1;
        if (stuff_err)  n_stuff  <= n_stuff + 1;
        if (can_hi_out) n_ack    <= n_ack + 1;
        if (valid2)     n_valid2 <= n_valid2 + 1;
    end

    function automatic bitq_t stuff_bits(input bitq_t f);
        bitq_t s;
        logic rv = 1'b1;
        int rl = 0;
        foreach (f[i]) begin
            s.push_back(f[i]);
            if (rl != 0 && f[i] == rv) rl++;
            else begin rv = f[i]; rl = 1; end
            if (rl == 5) begin s.push_back(~rv); rv = ~rv; rl = 1; end
        end
        return s;
    endfunction

    // Complete on-bus frame: fields, CRC, optional stuffing, then delimiters, EOF, intermission
    function automatic bitq_t frame_bits(input logic [10:0] id, input logic rtr, input logic ide,
                                         input logic [3:0] dlc, input logic [63:0] data,
                                         input int crc_flip, input logic do_stuff);
        bitq_t f;
        logic [14:0] c = '0;
        int nb = rtr ? 0 : (dlc > 8 ? 8 : int'(dlc));
        f.push_back(1'b0);
        for (int i = 10; i >= 0; i--) f.push_back(id[i]);
        f.push_back(rtr); f.push_back(ide); f.push_back(1'b0);
        for (int i = 3; i >= 0; i--) f.push_back(dlc[i]);
        for (int i = 0; i < nb * 8; i++) f.push_back(data[63 - i]);
        foreach (f[i]) c = {c[13:0], 1'b0} ^ ((f[i] ^ c[14]) ? 15'h4599 : 15'h0);
        if (crc_flip >= 0) c[crc_flip] = ~c[crc_flip];
        for (int i = 14; i >= 0; i--) f.push_back(c[i]);
        if (do_stuff) f = stuff_bits(f);
        for (int i = 0; i < 13; i++) f.push_back(1'b1);
        return f;
    endfunction

    task automatic set_expect(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data);
        int nb = rtr ? 0 : (dlc > 8 ? 8 : int'(dlc));
        exp_id = id; exp_rtr = rtr; exp_dlc = dlc; exp_data = '0;
        for (int i = 0; i < nb * 8; i++) exp_data[63 - i] = data[63 - i];
    endtask

    task automatic snap();
        b_valid = n_valid; b_crc = n_crc; b_form = n_form; b_stuff = n_stuff;
        b_ack = n_ack; b_valid2 = n_valid2;
    endtask

    task automatic idle(input int nbits);
        tx = 1'b1; tx2 = 1'b1;
        repeat (nbits * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send(input bitq_t q, input int bus);
        foreach (q[i]) begin
            if (bus == 0) tx = q[i]; else tx2 = q[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        tx = 1'b1; tx2 = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({rx_valid, crc_err, form_err, stuff_err, busy, can_hi_out, can_lo_out} !== 7'b0000001) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 0000001",
                     {rx_valid, crc_err, form_err, stuff_err, busy, can_hi_out, can_lo_out});
        end
        tests_run++;
        if ({rx_id, rx_rtr, rx_dlc, rx_data} !== '0) begin
            tests_failed++; $display("FAIL reset_fields got %h want 0", {rx_id, rx_rtr, rx_dlc, rx_data});
        end
        rst_n = 1'b1;
        idle(12);
    endtask

    task automatic test_basic_frame();
        snap();
        send(frame_bits(11'h123, 1'b0, 1'b0, 4'd1, 64'h8900_0000_0000_0000, -1, 1'b1), 0);
        idle(2);
        set_expect(11'h123, 1'b0, 4'd1, 64'h8900_0000_0000_0000);
        tests_run++;
        if (n_valid - b_valid !== 1) begin tests_failed++; $display("FAIL basic_valid got %0d want 1", n_valid - b_valid); end
        tests_run++;
        if (n_crc + n_form + n_stuff - b_crc - b_form - b_stuff !== 0) begin
            tests_failed++; $display("FAIL basic_errs got %0d want 0", n_crc + n_form + n_stuff - b_crc - b_form - b_stuff);
        end
        tests_run++;
        if (rx_id !== 11'h123) begin tests_failed++; $display("FAIL basic_id got %h want 123", rx_id); end
        tests_run++;
        if ({rx_rtr, rx_dlc} !== 5'h01) begin tests_failed++; $display("FAIL basic_rtr_dlc got %h want 01", {rx_rtr, rx_dlc}); end
        tests_run++;
        if (rx_data !== 64'h8900_0000_0000_0000) begin tests_failed++; $display("FAIL basic_data got %h want 8900000000000000", rx_data); end
        tests_run++;
        if (n_ack - b_ack !== CPB) begin tests_failed++; $display("FAIL basic_ack got %0d want %0d", n_ack - b_ack, CPB); end
        idle(10);
    endtask

    task automatic test_crc_error();
        int flip = int'($urandom_range(0, 14));
        snap();
        send(frame_bits(11'h123, 1'b0, 1'b0, 4'd1, 64'h8900_0000_0000_0000, flip, 1'b1), 0);
        idle(2);
        tests_run++;
        if (n_crc - b_crc !== 1) begin tests_failed++; $display("FAIL crc_pulse got %0d want 1", n_crc - b_crc); end
        tests_run++;
        if (n_valid + n_form + n_stuff - b_valid - b_form - b_stuff !== 0) begin
            tests_failed++; $display("FAIL crc_other got %0d want 0", n_valid + n_form + n_stuff - b_valid - b_form - b_stuff);
        end
        tests_run++;
        if (n_ack - b_ack !== 0) begin tests_failed++; $display("FAIL crc_no_ack got %0d want 0", n_ack - b_ack); end
        tests_run++;
        if ({rx_id, rx_rtr, rx_dlc, rx_data} !== {exp_id, exp_rtr, exp_dlc, exp_data}) begin
            tests_failed++; $display("FAIL crc_fields_kept got %h want %h", {rx_id, rx_rtr, rx_dlc, rx_data}, {exp_id, exp_rtr, exp_dlc, exp_data});
        end
        idle(10);
    endtask

    // Remote frame, DLC 15 data frame, then random frames against the model
    task automatic test_frames();
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin id = 11'h7FF; rtr = 1'b1; dlc = 4'd8; end
            else if (k == 1) begin id = 11'($urandom); rtr = 1'b0; dlc = 4'd15; end
            else begin id = 11'($urandom); rtr = ($urandom_range(0, 3) == 0); dlc = 4'($urandom); end
            data = {$urandom, $urandom};
            snap();
            send(frame_bits(id, rtr, 1'b0, dlc, data, -1, 1'b1), 0);
            idle(2);
            set_expect(id, rtr, dlc, data);
            tests_run++;
            if (n_valid - b_valid !== 1 || n_crc + n_form + n_stuff - b_crc - b_form - b_stuff !== 0) begin
                tests_failed++; $display("FAIL frame%0d_pulses valid %0d errs %0d want 1/0", k, n_valid - b_valid,
                                         n_crc + n_form + n_stuff - b_crc - b_form - b_stuff);
            end
            tests_run++;
            if ({rx_id, rx_rtr, rx_dlc} !== {exp_id, exp_rtr, exp_dlc}) begin
                tests_failed++; $display("FAIL frame%0d_hdr got %h want %h", k, {rx_id, rx_rtr, rx_dlc}, {exp_id, exp_rtr, exp_dlc});
            end
            tests_run++;
            if (rx_data !== exp_data) begin tests_failed++; $display("FAIL frame%0d_data got %h want %h", k, rx_data, exp_data); end
            idle(10);
        end
    endtask

    task automatic test_stuff_error();
        bitq_t raw;
        logic [10:0] id = 11'($urandom);
        logic [63:0] data = {$urandom, $urandom};
        for (int i = 0; i < 12; i++) raw.push_back(1'b0);
        for (int i = 0; i < 3; i++) raw.push_back(1'b1);
        snap();
        send(raw, 0);
        send(frame_bits(id, 1'b0, 1'b0, 4'd2, data, -1, 1'b1), 0);
        idle(2);
        tests_run++;
        if (n_stuff - b_stuff !== 1) begin tests_failed++; $display("FAIL stuff_pulse got %0d want 1", n_stuff - b_stuff); end
        tests_run++;
        if (n_valid + n_crc + n_form - b_valid - b_crc - b_form !== 0) begin
            tests_failed++; $display("FAIL stuff_ignored got %0d want 0", n_valid + n_crc + n_form - b_valid - b_crc - b_form);
        end
        idle(10);
        snap();
        send(frame_bits(id, 1'b0, 1'b0, 4'd2, data, -1, 1'b1), 0);
        idle(2);
        set_expect(id, 1'b0, 4'd2, data);
        tests_run++;
        if (n_valid - b_valid !== 1) begin tests_failed++; $display("FAIL stuff_recover got %0d want 1", n_valid - b_valid); end
        tests_run++;
        if ({rx_id, rx_data} !== {exp_id, exp_data}) begin
            tests_failed++; $display("FAIL stuff_recover_fields got %h want %h", {rx_id, rx_data}, {exp_id, exp_data});
        end
        idle(10);
    endtask

    task automatic test_form_errors();
        bitq_t q;
        for (int k = 0; k < 3; k++) begin
            q = frame_bits(11'($urandom), 1'b0, (k == 2), 4'd3, {$urandom, $urandom}, -1, 1'b1);
            if (k == 0) q[q.size() - 7] = 1'b0;
            if (k == 1) q[q.size() - 13] = 1'b0;
            snap();
            send(q, 0);
            idle(2);
            tests_run++;
            if (n_form - b_form !== 1) begin tests_failed++; $display("FAIL form%0d_pulse got %0d want 1", k, n_form - b_form); end
            tests_run++;
            if (n_valid + n_crc + n_stuff - b_valid - b_crc - b_stuff !== 0) begin
                tests_failed++; $display("FAIL form%0d_other got %0d want 0", k, n_valid + n_crc + n_stuff - b_valid - b_crc - b_stuff);
            end
            tests_run++;
            if (n_ack - b_ack !== ((k == 0) ? CPB : 0)) begin
                tests_failed++; $display("FAIL form%0d_ack got %0d want %0d", k, n_ack - b_ack, (k == 0) ? CPB : 0);
            end
            tests_run++;
            if ({rx_id, rx_data} !== {exp_id, exp_data}) begin
                tests_failed++; $display("FAIL form%0d_kept got %h want %h", k, {rx_id, rx_data}, {exp_id, exp_data});
            end
            idle(10);
        end
    endtask

    task automatic test_reset_mid_frame();
        bitq_t q = frame_bits(11'($urandom), 1'b0, 1'b0, 4'd8, {$urandom, $urandom}, -1, 1'b1);
        logic [10:0] id = 11'($urandom);
        logic [63:0] data = {$urandom, $urandom};
        snap();
        send(q[0:29], 0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rx_valid, crc_err, form_err, stuff_err, busy, can_hi_out, can_lo_out} !== 7'b0000001) begin
            tests_failed++; $display("FAIL midrst_ctrl got %b want 0000001",
                                     {rx_valid, crc_err, form_err, stuff_err, busy, can_hi_out, can_lo_out});
        end
        tests_run++;
        if ({rx_id, rx_rtr, rx_dlc, rx_data} !== '0) begin
            tests_failed++; $display("FAIL midrst_fields got %h want 0", {rx_id, rx_rtr, rx_dlc, rx_data});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send(frame_bits(id, 1'b0, 1'b0, 4'd4, data, -1, 1'b1), 0);
        idle(2);
        tests_run++;
        if (n_valid + n_crc + n_form + n_stuff - b_valid - b_crc - b_form - b_stuff !== 0) begin
            tests_failed++; $display("FAIL midrst_pulses got %0d want 0",
                                     n_valid + n_crc + n_form + n_stuff - b_valid - b_crc - b_form - b_stuff);
        end
        idle(10);
        snap();
        send(frame_bits(id, 1'b0, 1'b0, 4'd4, data, -1, 1'b1), 0);
        idle(2);
        set_expect(id, 1'b0, 4'd4, data);
        tests_run++;
        if (n_valid - b_valid !== 1 || rx_data !== exp_data) begin
            tests_failed++; $display("FAIL midrst_recover got %0d/%h want 1/%h", n_valid - b_valid, rx_data, exp_data);
        end
        idle(10);
    endtask

    task automatic test_no_stuff();
        snap();
        send(frame_bits(11'h123, 1'b0, 1'b0, 4'd1, 64'h8900_0000_0000_0000, -1, 1'b0), 1);
        idle(2);
        tests_run++;
        if (n_valid2 - b_valid2 !== 1) begin tests_failed++; $display("FAIL nostuff_valid got %0d want 1", n_valid2 - b_valid2); end
        tests_run++;
        if ({id2, rtr2, dlc2, data2} !== {11'h123, 1'b0, 4'd1, 64'h8900_0000_0000_0000}) begin
            tests_failed++; $display("FAIL nostuff_fields got %h want 123/0/1/8900000000000000", {id2, rtr2, dlc2, data2});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_crc_error();
        test_frames();
        test_stuff_error();
        test_form_errors();
        test_reset_mid_frame();
        test_no_stuff();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/can_frame_receiver.md
# can_frame_receiver

Receive-side CAN 2.0A node: samples the bus, hard-syncs on start-of-frame, removes stuff bits, and parses standard-format data and remote frames into ID, RTR, DLC and data fields. Checks CRC-15, form and stuffing, drives the dominant ACK slot on a good CRC, and presents each completed frame with a one-cycle valid strobe. It pairs with `custom_can_node`, the transmit-side node, on the same `can_hi`/`can_lo` bus.

## Interface
- `CLKS_PER_BIT`, 8 — `can_clk` cycles per nominal bit time (≥4).
- `SAMPLE_POINT`, 5 — bit-counter value at which the bus is sampled (1..CLKS_PER_BIT-2).
- `STUFF_EN`, 1 — 1: destuff SOF..CRC end and check stuffing; 0: no stuff bits expected and no stuff check.
- `can_clk` in 1 — sole clock; everything is synchronous to its rising edge.
- `reset` in 1 — asynchronous, active-low (0 = reset).
- `can_lo_in` in 1 — bus bit (1 = recessive, 0 = dominant); passes through a 2-flop synchronizer.
- `can_hi_out` in/out: out 1 — 1 only while driving dominant ACK.
- `can_lo_out` out 1 — 0 only while driving dominant ACK, else 1.
- `rx_id` out 11 — received identifier.
- `rx_rtr` out 1 — RTR bit of the received frame.
- `rx_dlc` out 4 — DLC as received (raw).
- `rx_data` out 64 — first byte in [63:56]; unused bytes zero.
- `rx_valid` out 1 — one-cycle pulse: frame complete; `rx_*` are stable until the next `rx_valid`.
- `crc_err` out 1 — one-cycle pulse.
- `form_err` out 1 — one-cycle pulse.
- `stuff_err` out 1 — one-cycle pulse.
- `busy` out 1 — 1 in any state other than IDLE/INTEGRATE.

## Operation
States and transitions:
- **INTEGRATE**: entered from reset. Count recessive samples. Any dominant sample clears the count. 11 consecutive recessive samples → IDLE.
- **IDLE**: a synchronized 1→0 edge zeros the bit counter (hard sync). A dominant sample at SAMPLE_POINT → ARB. A recessive sample (glitch) → IDLE.
- **ARB**: 11 ID bits, MSB first, then RTR → CTRL.
- **CTRL**: IDE, r0, then DLC[3:0].
  - IDE=1 → `form_err`, ERROR.
  - Byte count = 0 if RTR, else min(DLC,8).
  - Count 0 → CRC; otherwise → DATA.
- **DATA**: 8×count bits, MSB first → CRC.
- **CRC**: 15 bits → CRC_DEL.
- **CRC_DEL**:
  - Dominant → `form_err`, ERROR.
  - Received CRC ≠ computed → `crc_err`, ERROR (no ACK).
  - Otherwise → ACK.
- **ACK**: drive dominant for the whole slot → ACK_DEL.
- **ACK_DEL**: dominant → `form_err`, ERROR; else → EOF.
- **EOF**: 7 recessive bits.
  - Any dominant → `form_err`, ERROR.
  - After the 7th → pulse `rx_valid`, update `rx_*`, → INTEGRATE (3-bit intermission + idle collapse into 11 recessive).
- **ERROR**: → INTEGRATE. `rx_*` are not updated.

CRC:
- CRC-15, polynomial 0x4599, init 0, over destuffed bits SOF through last data bit.
- Shift: crc_next = {crc[13:0],0} ^ (bit ^ crc[14] ? 0x4599 : 0).

Stuffing (STUFF_EN=1, SOF through last CRC bit):
- Track a run of equal destuffed-or-stuff samples.
- After 5 equal bits, the next sample is a stuff bit: discarded, not shifted into CRC or fields.
- Stuff bit equal to the run → `stuff_err`, ERROR.
- The run counter restarts at 1 with the stuff bit's value.

## Timing
- Bit counter runs 0..CLKS_PER_BIT-1 and wraps. Sampling happens at SAMPLE_POINT. Sampling latency is 2 cycles of synchronizer.
- All state transitions take effect on the sample clock.
- Error pulses assert in the cycle after the offending sample.
- ACK drive asserts the cycle the counter wraps to 0 after the CRC_DEL sample, and lasts exactly CLKS_PER_BIT cycles.
- `rx_valid` asserts the cycle after the 7th EOF sample. `rx_*` update in that same cycle.
- At most one of `rx_valid`/`crc_err`/`form_err`/`stuff_err` asserts per frame.

Reset values:
- All outputs 0, except `can_lo_out`=1.
- State = INTEGRATE. Counters 0. CRC 0.
- Reset mid-frame aborts silently: no pulse, and `rx_*` are cleared.

## Test plan
- Reset, 11 recessive bits, then frame ID 0x123, RTR 0, DLC 1, data 0x89, correct CRC, stuffed → `rx_valid` once; `rx_id`=0x123, `rx_dlc`=1, `rx_data`=0x8900_0000_0000_0000; ACK dominant for exactly 8 cycles.
- Same frame with one CRC bit flipped (restuffed) → `crc_err` pulse at CRC_DEL; no ACK drive; no `rx_valid`; `rx_*` unchanged.
- Remote frame ID 0x7FF, RTR 1, DLC 8 → `rx_valid`; `rx_rtr`=1, `rx_dlc`=8, `rx_data`=0. Also DLC 15 data frame → 8 bytes captured, `rx_dlc`=15.
- Six consecutive dominant bits inside the ID field → `stuff_err`. Next frame is ignored until 11 recessive bits, then a valid frame is received.
- Dominant bit at EOF bit 4 → `form_err`. Dominant CRC delimiter in a separate frame → `form_err`. Frame with IDE=1 → `form_err`.
- Drop `reset` low mid-DATA → outputs return to reset values immediately, no pulses. Frame sent before 11 recessive bits have elapsed after release → ignored.
- STUFF_EN=0, frame ID 0x123 data 0x89 with no stuff bits → `rx_valid`, correct fields.
